// File: rtl/soc_uart_pkg.sv
// Shared UART definitions for the Reed-Solomon link (transmitter and receiver).
// Contents:
//   BAUD_DIV_DEF - default clock cycles per UART bit (864 at a 10 ns clock)
//   DATA_W       - payload width of one UART frame
//   uart_state_t - frame state: IDLE, START, DATA, PARITY, STOP
//   even_parity  - parity bit for a payload byte (XOR of all bits)
package soc_uart_pkg;
  localparam int BAUD_DIV_DEF = 864;
  localparam int DATA_W       = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a show-ahead read port (dout is the current head).
// Ports:
//   clk, reset   - clock, asynchronous active-high reset (empties the FIFO)
//   push, din    - write din at the tail this edge
//   pop, dout    - dout is the head entry; pop advances past it this edge
//   full, empty  - occupancy flags
//   count        - occupancy, AW+1 bits so DEPTH itself is representable
// The caller must not push when full without a simultaneous pop, and must
// never pop when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;

  // Pointers wrap naturally modulo DEPTH (DEPTH is a power of 2).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage carries no reset; stale entries are unreachable once the
  // pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  assign dout  = mem[rptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
endmodule

// File: rtl/rs_uart_transmitter.sv
// Buffers decoded RS bytes and serialises them on a UART line.
// Frame: start(0), 8 data bits LSB first, even parity, stop(1); each bit
// lasts BAUD_DIV clocks, so a frame is 11*BAUD_DIV clocks. Frames run
// back-to-back while the FIFO holds data.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   decoded_data        - byte from the decoder
//   output_valid, CEO   - byte accepted when both are high at a clk edge
//   Tx_D                - registered serial output, idles high
//   tx_busy             - registered, high for the whole of each frame
//   fifo_full           - FIFO holds FIFO_DEPTH bytes
//   overflow            - sticky: a byte was dropped because FIFO was full
module rs_uart_transmitter
  import soc_uart_pkg::*;
#(
  parameter int BAUD_DIV   = BAUD_DIV_DEF,
  parameter int FIFO_DEPTH = 256,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] decoded_data,
  input  logic              output_valid,
  input  logic              CEO,
  output logic              Tx_D,
  output logic              tx_busy,
  output logic              fifo_full,
  output logic              overflow
);
  localparam int             CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [ADDR_W:0]  FULL_CNT = (ADDR_W+1)'(FIFO_DEPTH);

  uart_state_t       state, state_nxt;
  logic [CNT_W-1:0]  baud_cnt, baud_cnt_nxt;
  logic [2:0]        bit_idx, bit_idx_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic              par, par_nxt;
  logic              tx_nxt, busy_nxt;
  logic              bit_end;

  logic              accept, push, pop;
  logic              ff_full, ff_empty;
  logic [DATA_W-1:0] ff_dout;
  logic [ADDR_W:0]   ff_count;

  // A full FIFO still takes a byte when the transmitter pops on the same
  // edge; pop never depends on push, so there is no combinational loop.
  assign accept    = output_valid && CEO;
  assign push      = accept && (!ff_full || pop);
  assign fifo_full = (ff_count == FULL_CNT);
  assign bit_end   = (baud_cnt == CNT_LAST);

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH),
    .AW    (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (decoded_data),
    .dout  (ff_dout),
    .full  (ff_full),
    .empty (ff_empty),
    .count (ff_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      Tx_D     <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      shreg    <= shreg_nxt;
      par      <= par_nxt;
      Tx_D     <= tx_nxt;
      tx_busy  <= busy_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        overflow <= 1'b0;
    else if (accept && ff_full && !pop) overflow <= 1'b1;
  end

  // Next-state logic. Tx_D/tx_busy are computed one cycle ahead so the
  // line toggles on the same edge as the state change.
  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt + 1'b1;
    bit_idx_nxt  = bit_idx;
    shreg_nxt    = shreg;
    par_nxt      = par;
    tx_nxt       = Tx_D;
    busy_nxt     = tx_busy;
    pop          = 1'b0;

    case (state)
      IDLE: begin
        baud_cnt_nxt = '0;
        tx_nxt       = 1'b1;
        busy_nxt     = 1'b0;
        if (!ff_empty) begin
          pop         = 1'b1;
          shreg_nxt   = ff_dout;
          par_nxt     = even_parity(ff_dout);
          bit_idx_nxt = '0;
          tx_nxt      = 1'b0;
          busy_nxt    = 1'b1;
          state_nxt   = START;
        end
      end

      START: begin
        if (bit_end) begin
          baud_cnt_nxt = '0;
          bit_idx_nxt  = '0;
          tx_nxt       = shreg[0];
          state_nxt    = DATA;
        end
      end

      DATA: begin
        if (bit_end) begin
          baud_cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            tx_nxt    = par;
            state_nxt = PARITY;
          end else begin
            // Shift so the next bit is always at position 0 after the edge.
            bit_idx_nxt = bit_idx + 3'd1;
            shreg_nxt   = {1'b0, shreg[DATA_W-1:1]};
            tx_nxt      = shreg[1];
          end
        end
      end

      PARITY: begin
        if (bit_end) begin
          baud_cnt_nxt = '0;
          tx_nxt       = 1'b1;
          state_nxt    = STOP;
        end
      end

      STOP: begin
        if (bit_end) begin
          baud_cnt_nxt = '0;
          if (!ff_empty) begin
            // Back-to-back: next start bit follows the stop bit directly.
            pop         = 1'b1;
            shreg_nxt   = ff_dout;
            par_nxt     = even_parity(ff_dout);
            bit_idx_nxt = '0;
            tx_nxt      = 1'b0;
            state_nxt   = START;
          end else begin
            tx_nxt    = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        baud_cnt_nxt = '0;
        tx_nxt       = 1'b1;
        busy_nxt     = 1'b0;
        state_nxt    = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_rs_uart_transmitter.sv
// Bench for rs_uart_transmitter. The main instance (depth 256) is checked by
// a line-level model: each accepted byte must appear as an 11-bit frame
// starting at max(push_edge+1, end of previous frame). A depth-4 instance
// covers the overflow case, decoded by a plain UART receiver.
module tb_rs_uart_transmitter;
  localparam int B  = 8;
  localparam int FB = 11 * B;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data, data_s;
  logic       valid, ceo, valid_s, ceo_s;
  logic       tx, busy, full, ovf;
  logic       tx_s, busy_s, full_s, ovf_s;

  always #5 clk = ~clk;

  rs_uart_transmitter #(.BAUD_DIV(B), .FIFO_DEPTH(256), .ADDR_W(8)) u_dut (
    .clk(clk), .reset(reset), .decoded_data(data), .output_valid(valid),
    .CEO(ceo), .Tx_D(tx), .tx_busy(busy), .fifo_full(full), .overflow(ovf));

  rs_uart_transmitter #(.BAUD_DIV(B), .FIFO_DEPTH(4), .ADDR_W(2)) u_small (
    .clk(clk), .reset(reset), .decoded_data(data_s), .output_valid(valid_s),
    .CEO(ceo_s), .Tx_D(tx_s), .tx_busy(busy_s), .fifo_full(full_s), .overflow(ovf_s));

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Edge counter and record of accepted bytes on the main instance.
  typedef struct { logic [7:0] d; int p; } push_t;
  push_t exp_q[$];
  int    cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset === 1'b0 && valid && ceo) exp_q.push_back('{d: data, p: cyc + 1});
  end

  // Line model for the main instance.
  bit mon_en = 0, in_frame = 0;
  int free_edge = 0, frames = 0, idle_busy = 0, last_end = 0;
  logic last_par;

  initial begin : mon
    int s, bad;
    push_t e;
    logic [10:0] ef, gb;
    bit aborted;
    forever begin
      @(negedge clk);
      if (!mon_en) continue;
      if (tx === 1'b0) begin
        s = cyc; in_frame = 1; aborted = 0; bad = 0; gb = '0;
        chk("frame_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else begin e.d = 8'h00; e.p = s - 1; end
        chk("start_edge", s, (e.p + 1 > free_edge) ? e.p + 1 : free_edge);
        free_edge = s + FB;
        ef = {1'b1, ^e.d, e.d, 1'b0};
        for (int i = 0; i < FB; i++) begin
          if (i > 0) @(negedge clk);
          if (!mon_en) begin aborted = 1; break; end
          if (tx !== ef[i/B] || busy !== 1'b1) bad++;
          if (i % B == B/2) gb[i/B] = tx;
        end
        in_frame = 0;
        if (!aborted) begin
          frames++;
          last_end = s + FB;
          last_par = gb[9];
          chk("frame_start", gb[0], 0);
          chk("frame_byte", gb[8:1], e.d);
          chk("frame_parity", gb[9], ^e.d);
          chk("frame_stop", gb[10], 1);
          chk("frame_shape", bad, 0);
        end
      end else if (busy === 1'b1) idle_busy++;
    end
  end

  // Plain receiver for the small instance.
  logic [7:0] got_s[$];
  int bad_s = 0;
  initial begin : rx_small
    logic [10:0] fr;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && tx_s === 1'b0) begin
        fr = '0;
        for (int i = 1; i < FB; i++) begin
          @(negedge clk);
          if (i % B == B/2) fr[i/B] = tx_s;
        end
        got_s.push_back(fr[8:1]);
        if (fr[0] !== 1'b0 || fr[9] !== ^fr[8:1] || fr[10] !== 1'b1) bad_s++;
      end
    end
  end

  task automatic push_byte(input logic [7:0] d);
    @(negedge clk);
    data = d; valid = 1'b1; ceo = 1'b1;
  endtask

  // Idle cycles with random noise on the inputs, never a qualified push.
  task automatic idle_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      data  = 8'($urandom);
      valid = 1'($urandom_range(0, 1));
      ceo   = valid ? 1'b0 : 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || in_frame) && n < budget) begin
      @(negedge clk); n++;
    end
    chk(tag, exp_q.size() + int'(in_frame), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #950000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int p0, f0, lows, n, tgt, bhigh;
    reset = 1'b0; valid = 0; ceo = 0; data = 0;
    valid_s = 0; ceo_s = 0; data_s = 0;
    #1 reset = 1'b1;
    #1;
    chk("rst_tx", tx, 1);       chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);   chk("rst_ovf", ovf, 0);
    chk("rst_tx_s", tx_s, 1);   chk("rst_full_s", full_s, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0; mon_en = 1;

    // Single byte, then parity corner bytes.
    push_byte(8'hA5); idle_cyc(1);
    drain("drain_a5", 3 * FB);
    chk("a5_par", last_par, 0);
    chk("a5_idle_tx", tx, 1); chk("a5_idle_busy", busy, 0);
    push_byte(8'h01); idle_cyc(1);
    drain("drain_01", 3 * FB);
    chk("par_01", last_par, 1);
    push_byte(8'h00); idle_cyc(1);
    drain("drain_00", 3 * FB);
    chk("par_00", last_par, 0);

    // output_valid without CEO writes nothing.
    f0 = frames; lows = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      data = 8'($urandom); valid = 1'b1; ceo = 1'b0;
    end
    idle_cyc(1); valid = 0;
    for (int i = 0; i < 2 * FB; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("ceo_gate_frames", frames, f0);
    chk("ceo_gate_tx", lows, 0);

    // Random bursts with random gaps, hitting every phase of a frame.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 12);
      for (int k = 0; k < n; k++) begin
        idle_cyc($urandom_range(0, FB + 5));
        push_byte(8'($urandom));
      end
      idle_cyc(1);
      drain("drain_rand", (n + 2) * FB);
    end

    // One decoder codeword: 188 consecutive bytes.
    f0 = frames;
    push_byte(8'd0); p0 = cyc + 1;
    for (int i = 1; i < 188; i++) push_byte(8'(i));
    idle_cyc(1);
    drain("drain_burst", 190 * FB);
    chk("burst_frames", frames - f0, 188);
    chk("burst_span", last_end - (p0 + 1), 188 * FB);
    chk("burst_ovf", ovf, 0);
    chk("burst_full", full, 0);

    // Overflow on the depth-4 instance: 6 pushes on consecutive edges.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 5) begin
        chk("small_full", full_s, 1);
        chk("small_ovf_pre", ovf_s, 0);
      end
      data_s = 8'h10 + 8'(i); valid_s = 1'b1; ceo_s = 1'b1;
    end
    @(negedge clk);
    valid_s = 1'b0; ceo_s = 1'b0;
    chk("small_full_drop", full_s, 1);
    chk("small_ovf", ovf_s, 1);
    n = 0;
    while (got_s.size() < 5 && n < 8 * FB) begin @(negedge clk); n++; end
    repeat (2 * FB) @(negedge clk);
    chk("small_count", got_s.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < got_s.size()) chk("small_order", got_s[k], 8'h10 + 8'(k));
    chk("small_frames_ok", bad_s, 0);
    chk("small_ovf_sticky", ovf_s, 1);
    chk("small_full_after", full_s, 0);

    // Reset in the middle of a data bit with 3 bytes buffered.
    push_byte(8'h5A); p0 = cyc + 1;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    idle_cyc(1); valid = 0;
    tgt = p0 + 1 + B + B/2 + 1;
    n = 0;
    while (cyc < tgt && n < 4 * FB) begin @(negedge clk); n++; end
    chk("rst_mid_busy_pre", busy, 1);
    mon_en = 0;
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_tx", tx, 1);
    chk("rst_mid_busy", busy, 0);
    exp_q.delete(); free_edge = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    lows = 0; bhigh = 0;
    for (int i = 0; i < 3 * FB; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) bhigh++;
    end
    chk("post_rst_tx", lows, 0);
    chk("post_rst_busy", bhigh, 0);
    mon_en = 1; f0 = frames;
    push_byte(8'h3C); idle_cyc(1);
    drain("drain_post_rst", 3 * FB);
    chk("post_rst_frames", frames - f0, 1);

    chk("idle_busy", idle_busy, 0);
    chk("main_ovf", ovf, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
